// File: rtl/chaos_display_ctrl.sv
// chaos_display_ctrl: startup enables, VGA pixel register and
// blanking-synchronous key select with timed core reset pulse.
// Optional feature: define AUTO_CYCLE_EN for idle-frame auto-advance.
module chaos_display_ctrl #(
  parameter int NUM_KEYS        = 10,
  parameter int SEL_W           = 4,
  parameter int TICK_DIV        = 1048576,
  parameter int DISP_DELAY      = 6,
  parameter int CALC_DELAY      = 15,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int RST_PULSE       = 8,
  parameter int AUTO_FRAMES     = 600
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                vnotactive,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [2:0]          pix_in,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [SEL_W-1:0]    sample_num,
  output logic                sel_valid,
  output logic                core_rst_n,
  output logic                disp_en,
  output logic                calc_en
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(CALC_DELAY + 1);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int PW = (RST_PULSE > 0) ? $clog2(RST_PULSE + 1) : 1;

  if ((2 ** SEL_W) < NUM_KEYS || CALC_DELAY <= DISP_DELAY ||
      DEBOUNCE_FRAMES < 1 || AUTO_FRAMES < 1) begin : g_bad_cfg
    $error("chaos_display_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    WAIT_BLANK,
    SCAN,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [SW-1:0]    start_q, start_d;
  logic             disp_en_q, disp_en_d;
  logic             calc_en_q, calc_en_d;
  logic [2:0]       rgb_q, rgb_d;
  logic [DW-1:0]    deb_q, deb_d, deb_inc;
  logic [SEL_W-1:0] last_q, last_d;
  logic [SEL_W-1:0] sample_q, sample_d;
  logic             lock_q, lock_d;
  logic             sel_valid_q, sel_valid_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             tick;
  logic             scan;
  logic             commit;
  logic             any_key;
  logic [SEL_W-1:0] cand;

`ifdef AUTO_CYCLE_EN
  localparam int IW = $clog2(AUTO_FRAMES + 1);
  logic [IW-1:0]    idle_q, idle_d;
`endif

  // Startup tick prescaler, saturating tick count and sticky enables
  always_comb begin
    tick    = (tick_q == TW'(TICK_DIV - 1));
    tick_d  = tick ? '0 : tick_q + 1'b1;
    start_d = start_q;
    if (tick && start_q != SW'(CALC_DELAY)) begin
      start_d = start_q + 1'b1;
    end
    disp_en_d = disp_en_q | (start_d >= SW'(DISP_DELAY));
    calc_en_d = calc_en_q | (start_d == SW'(CALC_DELAY));
    rgb_d     = disp_en_q ? pix_in : rgb_q;
  end

  // Lowest-index pressed key wins
  always_comb begin
    any_key = ~&key_n;
    cand    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (!key_n[i]) begin
        cand = SEL_W'(i);
      end
    end
  end

  // Key FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= WAIT_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Key FSM next state: one SCAN cycle per blanking interval
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_BLANK: if (vnotactive) state_d = SCAN;
      SCAN:       state_d = HOLD;
      HOLD:       if (!vnotactive) state_d = WAIT_BLANK;
      default:    state_d = WAIT_BLANK;
    endcase
  end

  // Key FSM outputs: debounce, lock, commit and reset pulse
  always_comb begin
    scan     = (state_q == SCAN);
    deb_d    = deb_q;
    last_d   = last_q;
    lock_d   = lock_q;
    sample_d = sample_q;
    commit   = 1'b0;
    deb_inc  = (deb_q == DW'(DEBOUNCE_FRAMES)) ? deb_q : deb_q + 1'b1;
    if (scan) begin
      if (!any_key) begin
        deb_d  = '0;
        lock_d = 1'b0;
      end else if (!lock_q) begin
        if (cand == last_q) begin
          deb_d = deb_inc;
        end else begin
          deb_d  = DW'(1);
          last_d = cand;
        end
        if (deb_d >= DW'(DEBOUNCE_FRAMES)) begin
          commit   = 1'b1;
          sample_d = cand;
          lock_d   = 1'b1;
          deb_d    = '0;
        end
      end
    end
`ifdef AUTO_CYCLE_EN
    idle_d = idle_q;
    if (scan) begin
      if (any_key) begin
        idle_d = '0;
      end else if (calc_en_q) begin
        idle_d = idle_q + 1'b1;
        if (idle_d == IW'(AUTO_FRAMES)) begin
          commit   = 1'b1;
          sample_d = (sample_q == SEL_W'(NUM_KEYS - 1)) ?
                     '0 : sample_q + 1'b1;
          idle_d   = '0;
        end
      end
    end
`endif
    sel_valid_d = commit;
    if (commit) begin
      pulse_d = PW'(RST_PULSE);
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - 1'b1;
    end else begin
      pulse_d = pulse_q;
    end
    core_rst_n_d = (pulse_d == '0);
  end

  // Datapath registers; reset pulse starts armed
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_q       <= '0;
      start_q      <= '0;
      disp_en_q    <= 1'b0;
      calc_en_q    <= 1'b0;
      rgb_q        <= 3'b111;
      deb_q        <= '0;
      last_q       <= '0;
      sample_q     <= '0;
      lock_q       <= 1'b0;
      sel_valid_q  <= 1'b0;
      pulse_q      <= PW'(RST_PULSE);
      core_rst_n_q <= 1'b0;
`ifdef AUTO_CYCLE_EN
      idle_q       <= '0;
`endif
    end else begin
      tick_q       <= tick_d;
      start_q      <= start_d;
      disp_en_q    <= disp_en_d;
      calc_en_q    <= calc_en_d;
      rgb_q        <= rgb_d;
      deb_q        <= deb_d;
      last_q       <= last_d;
      sample_q     <= sample_d;
      lock_q       <= lock_d;
      sel_valid_q  <= sel_valid_d;
      pulse_q      <= pulse_d;
      core_rst_n_q <= core_rst_n_d;
`ifdef AUTO_CYCLE_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign red        = rgb_q[2];
  assign green      = rgb_q[1];
  assign blue       = rgb_q[0];
  assign sample_num = sample_q;
  assign sel_valid  = sel_valid_q;
  assign core_rst_n = core_rst_n_q;
  assign disp_en    = disp_en_q;
  assign calc_en    = calc_en_q;

endmodule

// File: tb/tb_chaos_display_ctrl.sv
// tb_chaos_display_ctrl: directed vectors for startup, pixel path,
// key debounce/commit/lock, async reset and optional auto-advance.
module tb_chaos_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vnot;
  logic [9:0] key_n;
  logic [2:0] pix;
  logic       red, green, blue;
  logic [3:0] sample_num;
  logic       sel_valid, core_rst_n, disp_en, calc_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chaos_display_ctrl #(
    .NUM_KEYS(10),
    .SEL_W(4),
    .TICK_DIV(4),
    .DISP_DELAY(2),
    .CALC_DELAY(4),
    .DEBOUNCE_FRAMES(2),
    .RST_PULSE(3),
    .AUTO_FRAMES(3)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .vnotactive(vnot),
    .key_n(key_n),
    .pix_in(pix),
    .red(red),
    .green(green),
    .blue(blue),
    .sample_num(sample_num),
    .sel_valid(sel_valid),
    .core_rst_n(core_rst_n),
    .disp_en(disp_en),
    .calc_en(calc_en)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " rgb"}, {red, green, blue}, 3'b111);
    chk({tag, " sn"}, sample_num, 0);
    chk({tag, " sv"}, sel_valid, 0);
    chk({tag, " crn"}, core_rst_n, 0);
    chk({tag, " disp"}, disp_en, 0);
    chk({tag, " calc"}, calc_en, 0);
  endtask

  // One blanking interval; E is the edge ending SCAN
  task automatic frame(input string tag, input logic [9:0] kn,
                       input bit exp_c, input logic [3:0] exp_sn);
    key_n = kn;
    vnot  = 1'b1;
    tick();
    tick();
    chk({tag, " sv"}, sel_valid, exp_c);
    chk({tag, " sn"}, sample_num, exp_sn);
    chk({tag, " crn0"}, core_rst_n, !exp_c);
    vnot = 1'b0;
    tick();
    chk({tag, " sv1"}, sel_valid, 0);
    tick();
    chk({tag, " crn2"}, core_rst_n, !exp_c);
    tick();
    chk({tag, " crn3"}, core_rst_n, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    vnot  = 1'b0;
    key_n = '1;
    pix   = 3'b010;
    tick();
    tick();
    chk_rst("por");

    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 2) chk("crn c2", core_rst_n, 0);
      if (c == 3) chk("crn c3", core_rst_n, 1);
      if (c == 7) begin
        chk("disp c7", disp_en, 0);
        chk("rgb c7", {red, green, blue}, 3'b111);
      end
      if (c == 8) begin
        chk("disp c8", disp_en, 1);
        chk("rgb c8", {red, green, blue}, 3'b111);
      end
      if (c == 9) begin
        chk("rgb c9", {red, green, blue}, 3'b010);
        pix = 3'b101;
      end
      if (c == 10) chk("rgb c10", {red, green, blue}, 3'b101);
      if (c == 15) chk("calc c15", calc_en, 0);
      if (c == 16) chk("calc c16", calc_en, 1);
    end

    frame("k3 f1", ~10'h008, 0, 0);
    frame("k3 f2", ~10'h008, 1, 3);
    frame("k3 h1", ~10'h008, 0, 3);
    frame("k3 h2", ~10'h008, 0, 3);
    frame("k3 h3", ~10'h008, 0, 3);
    frame("rel a", '1, 0, 3);

    frame("k72 f1", ~10'h084, 0, 3);
    frame("k72 f2", ~10'h084, 1, 2);
    frame("rel b", '1, 0, 2);
    frame("k7 f1", ~10'h080, 0, 2);
    frame("k7 f2", ~10'h080, 1, 7);
    frame("k71 lk", ~10'h082, 0, 7);
    frame("rel c", '1, 0, 7);

    frame("k5 f1", ~10'h020, 0, 7);
    frame("k6 f2", ~10'h040, 0, 7);
    frame("k6 f3", ~10'h040, 1, 6);
    frame("rel d", '1, 0, 6);

    frame("k4 f1", ~10'h010, 0, 6);
    key_n = ~10'h010;
    vnot  = 1'b1;
    tick();
    tick();
    chk("k4 commit sv", sel_valid, 1);
    chk("k4 commit sn", sample_num, 4);
    tick();
    chk("k4 pulse", core_rst_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("mid pulse");

    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("fresh scan sv", sel_valid, 0);
    chk("fresh scan sn", sample_num, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("mid deb");
    vnot = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    frame("k4 r1", ~10'h010, 0, 0);
    frame("k4 r2", ~10'h010, 1, 4);
    frame("rel e", '1, 0, 4);

`ifdef AUTO_CYCLE_EN
    repeat (20) tick();
    chk("auto calc", calc_en, 1);
    frame("k9 f1", ~10'h200, 0, 4);
    frame("k9 f2", ~10'h200, 1, 9);
    frame("idle 1", '1, 0, 9);
    frame("idle 2", '1, 0, 9);
    frame("idle 3", '1, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
